// File: rtl/btn_event_reader_if.sv
// Event handshake between btn_event_reader (master) and its consumer (slave).
interface btn_event_reader_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_idx;
    logic       evt_long;

    modport master (output evt_valid, output evt_idx, output evt_long, input evt_ready);
    modport slave  (input evt_valid, input evt_idx, input evt_long, output evt_ready);
endinterface

// File: rtl/btn_event_reader.sv
// Five-button synchronizer/debouncer with a press-event queue on a valid/ready port.
// Define BTN_LONGPRESS_EN to add per-button long-press events (evt_long=1).
module btn_event_reader #(
    parameter logic [31:0] DEBOUNCE_CNT = 32'd500_000,
    parameter logic [31:0] LONG_CNT     = 32'd50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                btn,
    output logic [4:0]                btn_state,
    output logic                      overflow,
    btn_event_reader_if.master        evt
);

    logic [4:0]  sync1_q, sync2_q, state_q;
    logic [31:0] cnt_q [5];
    logic [4:0]  pending_q, pending_d, rise, clr;
    logic [4:0]  lpend_q, lfire, lclr;
    logic        valid_q, valid_d, long_q, long_d, ovf_q, ovf_d, free;
    logic [2:0]  idx_q, idx_d;

    function automatic logic [2:0] lowest(input logic [4:0] v);
        lowest = 3'd0;
        for (int unsigned i = 5; i > 0; i--)
            if (v[i-1]) lowest = 3'(i - 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2_q[i] == state_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEBOUNCE_CNT - 32'd1) begin
                    state_q[i] <= sync2_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Rising debounced edge, asserted on the same edge that updates state_q.
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < 5; i++)
            rise[i] = sync2_q[i] & ~state_q[i] & (cnt_q[i] == DEBOUNCE_CNT - 32'd1);
    end

`ifdef BTN_LONGPRESS_EN
    logic [31:0] hold_q [5];
    logic [4:0]  lpend_d;

    // Hold counter saturates at LONG_CNT so each press fires at most once.
    always_comb begin
        lfire = '0;
        for (int unsigned i = 0; i < 5; i++)
            lfire[i] = state_q[i] & (hold_q[i] == LONG_CNT - 32'd1);
        lpend_d = (lpend_q & ~lclr) | lfire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lpend_q <= '0;
            for (int unsigned i = 0; i < 5; i++) hold_q[i] <= '0;
        end else begin
            lpend_q <= lpend_d;
            for (int unsigned i = 0; i < 5; i++) begin
                if (!state_q[i])              hold_q[i] <= '0;
                else if (hold_q[i] != LONG_CNT) hold_q[i] <= hold_q[i] + 32'd1;
            end
        end
    end
`else
    assign lpend_q = '0;
    assign lfire   = '0;
`endif

    always_comb begin
        free    = ~valid_q | evt.evt_ready;
        valid_d = valid_q;
        idx_d   = idx_q;
        long_d  = long_q;
        clr     = '0;
        lclr    = '0;
        if (free) begin
            valid_d = 1'b0;
            if (|pending_q) begin
                valid_d = 1'b1;
                idx_d   = lowest(pending_q);
                long_d  = 1'b0;
                clr     = 5'd1 << idx_d;
            end else if (|lpend_q) begin
                valid_d = 1'b1;
                idx_d   = lowest(lpend_q);
                long_d  = 1'b1;
                lclr    = 5'd1 << idx_d;
            end
        end
        // A new press overrides a same-cycle clear; a press on a still-queued button is lost.
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = ovf_q | (|(rise & pending_q & ~clr)) | (|(lfire & lpend_q & ~lclr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            long_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            long_q    <= long_d;
            ovf_q     <= ovf_d;
        end
    end

    assign btn_state     = state_q;
    assign overflow      = ovf_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_idx   = idx_q;
    assign evt.evt_long  = long_q;

endmodule

// File: tb/tb_btn_event_reader.sv
// Directed bench for btn_event_reader with DEBOUNCE_CNT=4, LONG_CNT=20.
module tb_btn_event_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [4:0] btn_state;
    logic       overflow;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    typedef struct {
        logic [2:0] idx;
        logic       lng;
        int         cyc;
    } evt_t;
    evt_t evq[$];

    btn_event_reader_if evt_if ();

    btn_event_reader #(.DEBOUNCE_CNT(32'd4), .LONG_CNT(32'd20)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .btn_state (btn_state),
        .overflow  (overflow),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    // Record every accepted event with the cycle it was accepted on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
            evq.push_back('{idx: evt_if.evt_idx, lng: evt_if.evt_long, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        evt_if.evt_ready = 1'b0;
        tick(3);
        chk("rst_state", 32'(btn_state), 32'h0);
        chk("rst_valid", 32'(evt_if.evt_valid), 32'h0);
        chk("rst_idx",   32'(evt_if.evt_idx), 32'h0);
        chk("rst_long",  32'(evt_if.evt_long), 32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);
        rst = 1'b0;
        tick(2);

        // Clean press on button 2
        evt_if.evt_ready = 1'b1;
        btn = 5'b00100;
        tick(5);
        chk("clean_state5", 32'(btn_state), 32'h0);
        tick(1);
        chk("clean_state6", 32'(btn_state), 32'h4);
        chk("clean_valid6", 32'(evt_if.evt_valid), 32'h0);
        tick(1);
        chk("clean_valid7", 32'(evt_if.evt_valid), 32'h1);
        chk("clean_idx7",   32'(evt_if.evt_idx), 32'h2);
        chk("clean_long7",  32'(evt_if.evt_long), 32'h0);
        tick(1);
        chk("clean_valid8", 32'(evt_if.evt_valid), 32'h0);
        btn = '0;
        tick(10);
        chk("clean_count", 32'(evq.size()), 32'd1);
        chk("release_state", 32'(btn_state), 32'h0);
        evq.delete();

        // Bounce on button 0: 1,1,0,0 x5, then hold high
        for (int k = 0; k < 5; k++) begin
            btn = 5'b00001; tick(2);
            btn = 5'b00000; tick(2);
        end
        tick(2);
        chk("bounce_state", 32'(btn_state), 32'h0);
        chk("bounce_noevt", 32'(evq.size()), 32'd0);
        btn = 5'b00001;
        tick(5);
        chk("bounce_state5", 32'(btn_state), 32'h0);
        tick(1);
        chk("bounce_state6", 32'(btn_state), 32'h1);
        tick(4);
        chk("bounce_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) chk("bounce_idx", 32'(evq[0].idx), 32'h0);
        btn = '0;
        tick(8);
        evq.delete();

        // Simultaneous press 0,1,4 while stalled
        evt_if.evt_ready = 1'b0;
        btn = 5'b10011;
        tick(10);
        chk("sim_valid10", 32'(evt_if.evt_valid), 32'h1);
        chk("sim_idx10",   32'(evt_if.evt_idx), 32'h0);
        tick(10);
        chk("sim_idx20",   32'(evt_if.evt_idx), 32'h0);
        chk("sim_long20",  32'(evt_if.evt_long), 32'h0);
        evt_if.evt_ready = 1'b1;
        tick(3);
        chk("sim_valid_end", 32'(evt_if.evt_valid), 32'h0);
        chk("sim_count", 32'(evq.size()), 32'd3);
        if (evq.size() == 3) begin
            chk("sim_idx_a", 32'(evq[0].idx), 32'h0);
            chk("sim_idx_b", 32'(evq[1].idx), 32'h1);
            chk("sim_idx_c", 32'(evq[2].idx), 32'h4);
            chk("sim_gap_ab", 32'(evq[1].cyc - evq[0].cyc), 32'd1);
            chk("sim_gap_bc", 32'(evq[2].cyc - evq[1].cyc), 32'd1);
        end
        chk("sim_ovf", 32'(overflow), 32'h0);
        btn = '0;
        tick(8);
        evq.delete();

        // Overflow: output holds button 0, button 3 pressed twice
        evt_if.evt_ready = 1'b0;
        btn = 5'b00001; tick(8);
        btn = 5'b01001; tick(8);
        chk("ovf_first", 32'(overflow), 32'h0);
        btn = 5'b00001; tick(8);
        btn = 5'b01001; tick(8);
        chk("ovf_set",   32'(overflow), 32'h1);
        chk("ovf_hold_idx", 32'(evt_if.evt_idx), 32'h0);
        btn = '0;
        evt_if.evt_ready = 1'b1;
        tick(12);
        chk("ovf_count", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            chk("ovf_idx_a", 32'(evq[0].idx), 32'h0);
            chk("ovf_idx_b", 32'(evq[1].idx), 32'h3);
        end
        chk("ovf_sticky", 32'(overflow), 32'h1);
        evq.delete();

        // Reset with a loaded event and a pending one
        evt_if.evt_ready = 1'b0;
        btn = 5'b00011;
        tick(8);
        chk("mid_valid_pre", 32'(evt_if.evt_valid), 32'h1);
        #2;
        rst = 1'b1;
        btn = '0;
        #1;
        chk("mid_valid", 32'(evt_if.evt_valid), 32'h0);
        chk("mid_state", 32'(btn_state), 32'h0);
        chk("mid_ovf",   32'(overflow), 32'h0);
        tick(2);
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(15);
        chk("mid_noevt", 32'(evq.size()), 32'd0);

        // Button held across reset release
        rst = 1'b1;
        btn = 5'b00100;
        tick(2);
        rst = 1'b0;
        tick(12);
        chk("held_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) chk("held_idx", 32'(evq[0].idx), 32'h2);
        btn = '0;
        tick(8);
        evq.delete();

        // Long press on button 1
        btn = 5'b00010;
        tick(40);
        btn = '0;
        tick(10);
`ifdef BTN_LONGPRESS_EN
        chk("long_count", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            chk("long_idx_a",  32'(evq[0].idx), 32'h1);
            chk("long_lng_a",  32'(evq[0].lng), 32'h0);
            chk("long_idx_b",  32'(evq[1].idx), 32'h1);
            chk("long_lng_b",  32'(evq[1].lng), 32'h1);
        end
`else
        chk("long_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) begin
            chk("long_idx_a", 32'(evq[0].idx), 32'h1);
            chk("long_lng_a", 32'(evq[0].lng), 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
